// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU control path.
//   state_t          : sequencer states (IDLE/FETCH/DECODE/ISSUE/HALT)
//   OP_0..OP_7       : opcode values carried in instruction bits [7:5]
//   OP_JMP / OP_HLT  : opcodes the sequencer consumes itself
//   OPC_MSB/OPC_LSB  : opcode field position, OPR_W : operand field width
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    HALT
  } state_t;

  localparam logic [2:0] OP_0 = 3'd0;
  localparam logic [2:0] OP_1 = 3'd1;
  localparam logic [2:0] OP_2 = 3'd2;
  localparam logic [2:0] OP_3 = 3'd3;
  localparam logic [2:0] OP_4 = 3'd4;
  localparam logic [2:0] OP_5 = 3'd5;
  localparam logic [2:0] OP_6 = 3'd6;
  localparam logic [2:0] OP_7 = 3'd7;

  localparam logic [2:0] OP_JMP = OP_6;
  localparam logic [2:0] OP_HLT = OP_7;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int OPR_W   = 5;

  function automatic logic [2:0] opcode_of(input logic [7:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [OPR_W-1:0] operand_of(input logic [7:0] instr);
    return instr[OPR_W-1:0];
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
// Bundles the two handshakes of the sequencer.
//   Program memory : mem_req/mem_addr out, mem_ack/mem_rdata back
//   Decoder bus    : decoder/operand/op_valid out, op_ready back
// master = sequencer side, slave = memory + logic unit side.
// ---------------------------------------------------------------------------
interface control_sequencer_if;
  import cpu_pkg::*;

  logic             mem_req;
  logic [7:0]       mem_addr;
  logic             mem_ack;
  logic [7:0]       mem_rdata;
  logic [7:0]       decoder;
  logic [OPR_W-1:0] operand;
  logic             op_valid;
  logic             op_ready;

  modport master (
    output mem_req, mem_addr, decoder, operand, op_valid,
    input  mem_ack, mem_rdata, op_ready
  );

  modport slave (
    input  mem_req, mem_addr, decoder, operand, op_valid,
    output mem_ack, mem_rdata, op_ready
  );

endinterface

// File: rtl/onehot_dec3to8.sv
// ---------------------------------------------------------------------------
// onehot_dec3to8
// Combinational 3-to-8 one-hot decoder.
//   sel    in  3  binary select
//   onehot out 8  bit[sel] high, all others low
// ---------------------------------------------------------------------------
module onehot_dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign onehot[gi] = (sel == 3'(gi));
  end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Fetch/decode/issue state machine of the 8-bit CPU.
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   run     in   level, enables instruction fetching
//   bus     master modport: program memory req/ack + decoder bus valid/ready
//   pc      out  current program counter (also drives mem_addr)
//   halted  out  sequencer stopped by HLT or memory fault
//   fault   out  program memory did not answer within WAIT_LIMIT cycles
// Every output is a register; mem_addr is pc itself.
// ---------------------------------------------------------------------------
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0]  RESET_PC   = 8'h00,
  parameter logic [2:0]  JMP_OPCODE = OP_JMP,
  parameter logic [2:0]  HLT_OPCODE = OP_HLT,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  control_sequencer_if.master        bus,
  output logic [7:0]                 pc,
  output logic                       halted,
  output logic                       fault
);

  // Last count value that may still be followed by an ack; one more
  // ack-less cycle means the memory has timed out.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t           state;
  logic [7:0]       ir;
  logic [7:0]       wait_cnt;
  logic             mem_req_reg;
  logic             op_valid_reg;
  logic [7:0]       decoder_reg;
  logic [OPR_W-1:0] operand_reg;
  logic [2:0]       opcode;
  logic [7:0]       dec_onehot;

  assign opcode = opcode_of(ir);

  onehot_dec3to8 u_dec (
    .sel    (opcode),
    .onehot (dec_onehot)
  );

  assign bus.mem_req  = mem_req_reg;
  assign bus.mem_addr = pc;
  assign bus.decoder  = decoder_reg;
  assign bus.operand  = operand_reg;
  assign bus.op_valid = op_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ir           <= '0;
      wait_cnt     <= '0;
      mem_req_reg  <= 1'b0;
      op_valid_reg <= 1'b0;
      decoder_reg  <= '0;
      operand_reg  <= '0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state       <= FETCH;
            mem_req_reg <= 1'b1;
          end
        end

        FETCH: begin
          if (bus.mem_ack) begin
            ir          <= bus.mem_rdata;
            mem_req_reg <= 1'b0;
            wait_cnt    <= '0;
            state       <= DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            fault       <= 1'b1;
            halted      <= 1'b1;
            mem_req_reg <= 1'b0;
            state       <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DECODE: begin
          if (opcode == HLT_OPCODE) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (opcode == JMP_OPCODE) begin
            // Jumps are absorbed here; the target is limited to the
            // first 32 bytes because only the operand field carries it.
            pc <= {3'b000, operand_of(ir)};
            if (run) begin
              state       <= FETCH;
              mem_req_reg <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            decoder_reg  <= dec_onehot;
            operand_reg  <= operand_of(ir);
            op_valid_reg <= 1'b1;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          // decoder/operand are left untouched until the logic unit
          // takes them, so they stay stable while op_valid is high.
          if (bus.op_ready) begin
            op_valid_reg <= 1'b0;
            decoder_reg  <= '0;
            pc           <= pc + 8'd1;
            if (run) begin
              state       <= FETCH;
              mem_req_reg <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        HALT: begin
          halted       <= 1'b1;
          mem_req_reg  <= 1'b0;
          op_valid_reg <= 1'b0;
          decoder_reg  <= '0;
        end

        default: begin
          state        <= HALT;
          halted       <= 1'b1;
          mem_req_reg  <= 1'b0;
          op_valid_reg <= 1'b0;
          decoder_reg  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench for control_sequencer. Expected issues are queued when a
// program is loaded and popped by a monitor at each decoder-bus handshake;
// directed steps check timing, pc, halt, fault and reset behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_control_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    logic [7:0] decoder;
    logic [4:0] operand;
    logic [7:0] pc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] pc;
  logic       halted;
  logic       fault;
  logic [7:0] mem [256];

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb [$];

  control_sequencer_if bus ();

  assign bus.mem_ack   = bus.mem_req & ack_en;
  assign bus.mem_rdata = mem[bus.mem_addr];

  control_sequencer #(
    .RESET_PC   (8'h00),
    .JMP_OPCODE (3'd6),
    .HLT_OPCODE (3'd7),
    .WAIT_LIMIT (15)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .bus    (bus),
    .pc     (pc),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_hlt();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
  endtask

  // Holds reset for two cycles, releases it just after a rising edge.
  task automatic do_reset(input logic run_val);
    rst_n = 1'b0;
    run   = run_val;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic [4:0] o, input logic [7:0] p);
    exp_t e;
    e.decoder = d;
    e.operand = o;
    e.pc      = p;
    sb.push_back(e);
  endtask

  // Scoreboard + bus invariants, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.op_valid && bus.op_ready) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_issue: observed decoder %0h operand %0h pc %0h expected no issue",
               bus.decoder, bus.operand, pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("issue_decoder", bus.decoder, e.decoder);
        check("issue_operand", bus.operand, e.operand);
        check("issue_pc", pc, e.pc);
      end
    end
    check("req_valid_exclusive", bus.mem_req & bus.op_valid, 0);
    check("decoder_onehot",
          bus.op_valid ? 32'($countones(bus.decoder)) : 32'(bus.decoder),
          bus.op_valid ? 32'd1 : 32'd0);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    bus.op_ready = 1'b1;
    fill_hlt();

    // ---- two back-to-back ALU ops, immediate ack/ready ----
    mem[0] = 8'h25;
    mem[1] = 8'h41;
    rst_n = 1'b0;
    run   = 1'b1;
    tick();
    tick();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_op_valid", bus.op_valid, 0);
    check("rst_decoder", bus.decoder, 0);
    check("rst_operand", bus.operand, 0);
    check("rst_pc", pc, 8'h00);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    push(8'h02, 5'd5, 8'h00);
    push(8'h04, 5'd1, 8'h01);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      check($sformatf("t1_op_valid_c%0d", cyc), bus.op_valid, (cyc == 3 || cyc == 6));
      if (cyc == 1) check("t1_pc_c1", pc, 8'h00);
      if (cyc == 4) check("t1_pc_c4", pc, 8'h01);
      if (cyc == 7) check("t1_pc_c7", pc, 8'h02);
    end
    check("t1_halted", halted, 1);
    check("t1_sb_drained", sb.size(), 0);

    // ---- op_ready stalled 4 cycles on 8'h6A ----
    fill_hlt();
    mem[0] = 8'h6A;
    bus.op_ready = 1'b0;
    do_reset(1'b1);
    push(8'h08, 5'd10, 8'h00);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t2_valid_hold%0d", k), bus.op_valid, 1);
      check($sformatf("t2_decoder_hold%0d", k), bus.decoder, 8'h08);
      check($sformatf("t2_operand_hold%0d", k), bus.operand, 5'd10);
      check($sformatf("t2_pc_hold%0d", k), pc, 8'h00);
    end
    bus.op_ready = 1'b1;
    tick();
    check("t2_valid_after", bus.op_valid, 0);
    check("t2_decoder_after", bus.decoder, 0);
    check("t2_pc_after", pc, 8'h01);
    tick();
    tick();
    check("t2_halted", halted, 1);
    check("t2_sb_drained", sb.size(), 0);

    // ---- jump chain 0 -> 1F -> 03, then HLT ----
    fill_hlt();
    mem[0]  = 8'hDF;
    mem[31] = 8'hC3;
    mem[3]  = 8'hE0;
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      tick();
      check($sformatf("t3_no_issue_c%0d", cyc), bus.op_valid, 0);
      if (cyc == 3) check("t3_pc_jmp1", pc, 8'h1F);
      if (cyc == 5) check("t3_pc_jmp2", pc, 8'h03);
    end
    check("t3_halted", halted, 1);
    check("t3_fault", fault, 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("t3_halt_hold%0d", k), halted, 1);
      check($sformatf("t3_req_quiet%0d", k), bus.mem_req, 0);
    end
    check("t3_sb_drained", sb.size(), 0);

    // ---- memory never acks: fault after 15 FETCH cycles ----
    fill_hlt();
    ack_en = 1'b0;
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      check($sformatf("t5_mem_req_c%0d", cyc), bus.mem_req, (cyc <= 15));
      check($sformatf("t5_fault_c%0d", cyc), fault, (cyc >= 16));
    end
    check("t5_halted", halted, 1);
    ack_en = 1'b1;

    // ---- async reset in the middle of ISSUE ----
    fill_hlt();
    mem[0] = 8'h25;
    bus.op_ready = 1'b0;
    do_reset(1'b1);
    tick();
    tick();
    tick();
    check("t6a_valid_before", bus.op_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6a_op_valid", bus.op_valid, 0);
    check("t6a_decoder", bus.decoder, 0);
    check("t6a_operand", bus.operand, 0);
    check("t6a_mem_req", bus.mem_req, 0);
    check("t6a_pc", pc, 8'h00);
    check("t6a_halted", halted, 0);

    // ---- run dropped during DECODE ----
    fill_hlt();
    mem[0] = 8'h25;
    bus.op_ready = 1'b1;
    do_reset(1'b1);
    push(8'h02, 5'd5, 8'h00);
    tick();
    tick();
    run = 1'b0;
    tick();
    check("t6b_issue", bus.op_valid, 1);
    tick();
    check("t6b_valid_done", bus.op_valid, 0);
    check("t6b_pc", pc, 8'h01);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t6b_idle_req%0d", k), bus.mem_req, 0);
    end
    check("t6b_sb_drained", sb.size(), 0);

    // ---- 256 ALU ops with random ready; pc wraps FF -> 00 ----
    for (int i = 0; i < 256; i++) begin
      logic [2:0] opc;
      logic [7:0] idx;
      idx     = 8'(i);
      opc     = 3'(i % 6);
      mem[i]  = {opc, idx[4:0]};
      push(8'h01 << opc, idx[4:0], idx);
    end
    bus.op_ready = 1'b1;
    do_reset(1'b1);
    found = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (bus.op_valid && pc == 8'hFF) begin
        found = 1'b1;
        break;
      end
      bus.op_ready = ($urandom_range(0, 1) == 1);
    end
    check("t4_pc_ff_reached", found, 1);
    if (found) begin
      run = 1'b0;
      bus.op_ready = 1'b1;
      tick();
      check("t4_pc_wrap", pc, 8'h00);
      check("t4_mem_addr_wrap", bus.mem_addr, 8'h00);
      check("t4_valid_after", bus.op_valid, 0);
      tick();
      check("t4_idle_req", bus.mem_req, 0);
    end
    check("t4_sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/decode/issue state machine for the 8-bit CPU.
- Reads instruction bytes from program memory over a req/ack handshake.
- Decodes bits [7:5] into the one-hot 8-bit decoder bus consumed by the logic unit.
- Issues each operation over a valid/ready handshake; it is the producer end of the decoder bus.

Parameters:
- RESET_PC, 8'h00, PC value loaded at reset.
- JMP_OPCODE, 3'd6, opcode handled internally as absolute jump; never issued.
- HLT_OPCODE, 3'd7, opcode that stops the sequencer; never issued.
- WAIT_LIMIT, 15, max cycles mem_req may wait for mem_ack before fault (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; enables instruction fetching.
- mem_req  out  1  fetch request to program memory.
- mem_addr  out  8  fetch address (= pc).
- mem_ack  in  1  memory has valid data on mem_rdata this cycle.
- mem_rdata  in  8  instruction byte.
- decoder  out  8  one-hot operation select to logic unit.
- operand  out  5  instruction bits [4:0].
- op_valid  out  1  decoder/operand valid.
- op_ready  in  1  logic unit accepts operation.
- pc  out  8  current program counter.
- halted  out  1  sequencer stopped (HLT or fault).
- fault  out  1  memory timeout occurred.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, pc=RESET_PC, ir=0, wait counter=0.
  - mem_req=0, decoder=0, operand=0, op_valid=0, halted=0, fault=0.
  - Reset mid-operation aborts everything immediately; no partial issue survives.
- All outputs are registered; mem_addr is pc.
- States: IDLE, FETCH, DECODE, ISSUE, HALT.
- IDLE:
  - Outputs are quiet.
  - run=1 → FETCH next cycle.
- FETCH:
  - mem_req=1 and is held until mem_ack.
  - Wait counter increments each cycle without ack.
  - mem_ack=1 (including the first FETCH cycle) → ir<=mem_rdata, mem_req<=0, counter cleared, go DECODE.
  - Counter reaches WAIT_LIMIT without ack → fault<=1, halted<=1, mem_req<=0, go HALT.
- DECODE, one cycle:
  - opcode=ir[7:5].
  - HLT_OPCODE → halted<=1, go HALT; decoder stays 0.
  - JMP_OPCODE → pc<={3'b000, ir[4:0]}, go FETCH (or IDLE if run=0); nothing issued.
  - Otherwise → decoder<=8'b1<<opcode, operand<=ir[4:0], op_valid<=1, go ISSUE.
- ISSUE:
  - decoder, operand and op_valid are held stable until op_ready=1.
  - Handshake cycle → op_valid<=0, decoder<=0, pc<=pc+1 (mod 256; 8'hFF wraps to 8'h00).
  - After handshake, go FETCH if run=1, else IDLE.
- HALT:
  - Terminal; only reset exits.
  - halted=1, op_valid=0, mem_req=0, decoder=0.
- run deasserted mid-instruction: the current instruction completes, including handshakes; stops at the next FETCH boundary.
- Ordering invariants:
  - Exactly one decoder bit is high when op_valid=1; decoder=0 whenever op_valid=0.
  - mem_req and op_valid are never high in the same cycle.
- Throughput: with ack and ready both immediate, 3 cycles per instruction (FETCH, DECODE, ISSUE).

Decomposition:
- Shared package cpu_pkg holds:
  - state enum (IDLE/FETCH/DECODE/ISSUE/HALT)
  - opcode constants OP_0..OP_7, including OP_JMP=6 and OP_HLT=7
  - field slices OPC_MSB=7, OPC_LSB=5, OPR_W=5
- One natural sub-module: onehot_dec3to8 (combinational 3→8 one-hot), reusable by other units.

Test Plan:
- Reset with run=1, memory {8'h25, 8'h41}, ack and ready immediate:
  - decoder=8'h02 with operand=5, then decoder=8'h04 with operand=1.
  - op_valid pulses at cycles 3 and 6; pc goes 0→1→2.
- op_ready held low 4 cycles during ISSUE on 8'h6A (opcode 3): decoder=8'h08 and operand=10 held stable throughout; pc increments only on the ready cycle.
- Jump to 8'h1F, with mem[31]=8'hC3 (jump) and mem[3]=8'hE0:
  - pc→8'h03, nothing issued for either jump.
  - Then halted=1 and stays 1 for 20 cycles.
- pc=8'hFF holding an ALU op: after handshake pc=8'h00 and the next mem_addr=8'h00.
- mem_ack never asserted, WAIT_LIMIT=15: mem_req drops and fault=1, halted=1 after 15 FETCH cycles.
- Two reset cases:
  - rst_n pulsed low mid-ISSUE: all outputs 0 in the same cycle (async), pc=RESET_PC.
  - run=0 during DECODE: the instruction issues, then IDLE with mem_req=0.
